// File: rtl/midi_rx.sv
// MIDI serial receiver: 8N1 UART at BAUD, oversampled by clk.
// Ports: clk, rst (sync, active high), rx (async, idle high) -> rx_byte, rx_byte_valid.
module midi_rx #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 31250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid
);

  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(CPB);
  localparam logic [CW-1:0] HALF_M1 = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CPB - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      sh_q, sh_d;
  logic [7:0]      byte_q, byte_d;
  logic            valid_q, valid_d;
  logic            meta_q, rxs_q;

  // Two-flop synchronizer; idle level is high so it resets to 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      rxs_q  <= 1'b1;
    end else begin
      meta_q <= rx;
      rxs_q  <= meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        // Re-check the line at the middle of the start bit to reject glitches.
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (rxs_q) begin
            state_d = S_IDLE;
          end else begin
            bit_d   = '0;
            state_d = S_DATA;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d        = '0;
          sh_d[bit_q]  = rxs_q;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rxs_q) begin
            byte_d  = sh_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            // Framing error or break: wait for the line to return high.
            state_d = S_WAIT;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rx_byte       = byte_q;
  assign rx_byte_valid = valid_q;

endmodule

// File: tb/tb_midi_rx.sv
// Self-checking bench for midi_rx using a byte scoreboard.
// Runs with a reduced bit period (32 clocks) to keep simulation short.
module tb_midi_rx;

  localparam int CLK_FREQ = 3_200_000;
  localparam int BAUD     = 100_000;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int LAT      = 2 + CPB / 2 + 9 * CPB;
  localparam int GAP      = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_byte_valid;

  midi_rx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .rx_byte      (rx_byte),
    .rx_byte_valid(rx_byte_valid)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: log every valid pulse with its cycle stamp.
  logic [7:0]  obs_b[$];
  int unsigned obs_t[$];
  int          dbl = 0;
  logic        prev_v = 1'b0;
  always @(negedge clk) begin
    if (rx_byte_valid) begin
      obs_b.push_back(rx_byte);
      obs_t.push_back(cyc);
      if (prev_v) dbl++;
    end
    prev_v = rx_byte_valid;
  end

  logic [7:0]  exp_q[$];
  int          rd = 0;
  int          compares = 0;
  int          errs = 0;
  int unsigned t0 = 0;

  // Caller is always at a negedge; task ends at a negedge.
  task automatic send(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    if (stop) exp_q.push_back(b);
    t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (10) @(negedge clk);
    compares++;
    if (rx_byte !== 8'h00) begin
      errs++;
      $display("FAIL reset_byte: got %02h want 00", rx_byte);
    end
    compares++;
    if (rx_byte_valid !== 1'b0) begin
      errs++;
      $display("FAIL reset_valid: got %b want 0", rx_byte_valid);
    end
    rst = 1'b0;
    idle(GAP);
    compares++;
    if (obs_b.size() != 0) begin
      errs++;
      $display("FAIL reset_nopulse: got %0d pulses want 0", obs_b.size());
    end
    rd = obs_b.size();
  endtask

  task automatic test_single;
    logic [7:0] e;
    int unsigned lat;
    send(8'h55, 1'b1);
    idle(CPB);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compares++;
      if (rd >= obs_b.size()) begin
        errs++;
        $display("FAIL single_byte: got no pulse want %02h", e);
      end else begin
        if (obs_b[rd] !== e) begin
          errs++;
          $display("FAIL single_byte: got %02h want %02h", obs_b[rd], e);
        end
        lat = obs_t[rd] - t0;
        compares++;
        if (lat < LAT - 2 || lat > LAT + 2) begin
          errs++;
          $display("FAIL single_latency: got %0d want %0d+-2", lat, LAT);
        end
        rd++;
      end
    end
    compares++;
    if (obs_b.size() != rd) begin
      errs++;
      $display("FAIL single_extra: got %0d pulses want %0d", obs_b.size(), rd);
    end
  endtask

  task automatic test_two_bytes;
    logic [7:0] e;
    send(8'h12, 1'b1);
    idle(GAP);
    compares++;
    if (rx_byte !== 8'h12) begin
      errs++;
      $display("FAIL two_hold: got %02h want 12", rx_byte);
    end
    send(8'hFA, 1'b0 == 1'b0);
    idle(GAP);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compares++;
      if (rd >= obs_b.size()) begin
        errs++;
        $display("FAIL two_byte: got no pulse want %02h", e);
      end else begin
        if (obs_b[rd] !== e) begin
          errs++;
          $display("FAIL two_byte: got %02h want %02h", obs_b[rd], e);
        end
        rd++;
      end
    end
    compares++;
    if (obs_b.size() != rd) begin
      errs++;
      $display("FAIL two_extra: got %0d pulses want %0d", obs_b.size(), rd);
    end
    compares++;
    if (rx_byte !== 8'hFA) begin
      errs++;
      $display("FAIL two_final: got %02h want FA", rx_byte);
    end
  endtask

  task automatic test_glitch;
    logic [7:0] e;
    rx = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    idle(GAP);
    compares++;
    if (obs_b.size() != rd) begin
      errs++;
      $display("FAIL glitch_nopulse: got %0d pulses want %0d", obs_b.size(), rd);
    end
    compares++;
    if (dut.state_q !== 3'd0) begin
      errs++;
      $display("FAIL glitch_idle: got state %0d want 0", dut.state_q);
    end
    send(8'h12, 1'b1);
    idle(CPB);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compares++;
      if (rd >= obs_b.size()) begin
        errs++;
        $display("FAIL glitch_byte: got no pulse want %02h", e);
      end else begin
        if (obs_b[rd] !== e) begin
          errs++;
          $display("FAIL glitch_byte: got %02h want %02h", obs_b[rd], e);
        end
        rd++;
      end
    end
  endtask

  task automatic test_framing;
    logic [7:0] e;
    send(8'hA5, 1'b0);
    rx = 1'b0;
    repeat (5 * CPB) @(negedge clk);
    idle(2 * CPB);
    compares++;
    if (obs_b.size() != rd) begin
      errs++;
      $display("FAIL frame_nopulse: got %0d pulses want %0d", obs_b.size(), rd);
    end
    compares++;
    if (rx_byte !== 8'h12) begin
      errs++;
      $display("FAIL frame_hold: got %02h want 12", rx_byte);
    end
    send(8'h3C, 1'b1);
    idle(CPB);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compares++;
      if (rd >= obs_b.size()) begin
        errs++;
        $display("FAIL frame_next: got no pulse want %02h", e);
      end else begin
        if (obs_b[rd] !== e) begin
          errs++;
          $display("FAIL frame_next: got %02h want %02h", obs_b[rd], e);
        end
        rd++;
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] e;
    send(8'h90, 1'b1);
    send(8'h3C, 1'b1);
    send(8'h7F, 1'b1);
    idle(2 * CPB);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compares++;
      if (rd >= obs_b.size()) begin
        errs++;
        $display("FAIL b2b_byte: got no pulse want %02h", e);
      end else begin
        if (obs_b[rd] !== e) begin
          errs++;
          $display("FAIL b2b_byte: got %02h want %02h", obs_b[rd], e);
        end
        rd++;
      end
    end
    compares++;
    if (obs_b.size() != rd) begin
      errs++;
      $display("FAIL b2b_extra: got %0d pulses want %0d", obs_b.size(), rd);
    end
    compares++;
    if (dbl != 0) begin
      errs++;
      $display("FAIL b2b_double: got %0d double pulses want 0", dbl);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] e;
    rx = 1'b0;
    repeat (4 * CPB) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(GAP);
    compares++;
    if (obs_b.size() != rd) begin
      errs++;
      $display("FAIL mid_nopulse: got %0d pulses want %0d", obs_b.size(), rd);
    end
    compares++;
    if (rx_byte !== 8'h00) begin
      errs++;
      $display("FAIL mid_byte: got %02h want 00", rx_byte);
    end
    send(8'hC3, 1'b1);
    idle(CPB);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compares++;
      if (rd >= obs_b.size()) begin
        errs++;
        $display("FAIL mid_recover: got no pulse want %02h", e);
      end else begin
        if (obs_b[rd] !== e) begin
          errs++;
          $display("FAIL mid_recover: got %02h want %02h", obs_b[rd], e);
        end
        rd++;
      end
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_two_bytes;
    test_glitch;
    test_framing;
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errs);
    $finish;
  end

endmodule
